// File: rtl/pm_arbiter_if.sv
// Bundles the requester, response and program-memory signals of pm_arbiter.
// Latency: none (wires only).
// Backpressure: the ready signals are carried here; the arbiter drives them.
// Ports: fetch (f_*), aux (a_*) and PM (pm_*) groups. The master modport is
// the arbiter's view; the slave modport is the view of the requesters and PM
// model around it.
interface pm_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic            f_rd_i;
    logic [XLEN-1:0] f_addr_i;
    logic            f_ready_o;
    logic            f_rvalid_o;
    logic [XLEN-1:0] f_rdata_o;
    logic            f_flush_i;
    logic            a_rd_i;
    logic [XLEN-1:0] a_addr_i;
    logic            a_ready_o;
    logic            a_rvalid_o;
    logic [XLEN-1:0] a_rdata_o;
    logic            pm_rd_o;
    logic [XLEN-1:0] pm_addr_o;
    logic            pm_ready_i;
    logic            pm_rvalid_i;
    logic [XLEN-1:0] pm_rdata_i;

    modport master (
        input  f_rd_i, f_addr_i, f_flush_i, a_rd_i, a_addr_i,
        input  pm_ready_i, pm_rvalid_i, pm_rdata_i,
        output f_ready_o, f_rvalid_o, f_rdata_o,
        output a_ready_o, a_rvalid_o, a_rdata_o,
        output pm_rd_o, pm_addr_o
    );

    modport slave (
        output f_rd_i, f_addr_i, f_flush_i, a_rd_i, a_addr_i,
        output pm_ready_i, pm_rvalid_i, pm_rdata_i,
        input  f_ready_o, f_rvalid_o, f_rdata_o,
        input  a_ready_o, a_rvalid_o, a_rdata_o,
        input  pm_rd_o, pm_addr_o
    );
endinterface

// File: rtl/pm_arbiter.sv
// Shares one PM read port between fetch (port 0) and aux (port 1), routing in-order responses back.
// Latency: request and response paths are combinational (0 added cycles).
// Backpressure: the granted port's ready follows pm_ready_i; no grant while the in-flight tag FIFO is full.
// Ports: clk_i/rst_i (async active-high), bus (pm_arbiter_if.master),
// outstanding_o (registered FIFO count), proto_err_o (sticky orphan-response flag).
module pm_arbiter #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int MAX_WAIT        = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pm_arbiter_if.master       bus,
    output logic [3:0]         outstanding_o,
    output logic               proto_err_o
);
    // Tag FIFO storage is sized for the largest legal depth; only the first
    // MAX_OUTSTANDING slots are ever addressed.
    logic [3:0] count_q, count_d;
    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [7:0] tag_q, tag_d;     // 0 = fetch, 1 = aux
    logic [7:0] disc_q, disc_d;   // response to be dropped (flushed fetch)
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       proto_err_q, proto_err_d;

    logic pop, push, full, a_prio, grant_a, grant_f;
    logic head_tag, head_disc;

    function automatic logic [2:0] ptr_inc(input logic [2:0] p);
        return (p == 3'(MAX_OUTSTANDING - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    always_comb begin
        head_tag  = tag_q[rd_ptr_q];
        head_disc = disc_q[rd_ptr_q];
        pop       = !rst_i && bus.pm_rvalid_i && (count_q != 4'd0);
        // A same-cycle pop frees a slot for this cycle's request.
        full      = (count_q - {3'd0, pop}) == 4'(MAX_OUTSTANDING);
        a_prio    = (wait_cnt_q == 8'(MAX_WAIT));
        grant_a   = !rst_i && !full && bus.a_rd_i && (a_prio || !bus.f_rd_i);
        grant_f   = !rst_i && !full && bus.f_rd_i && !grant_a;
        push      = (grant_a || grant_f) && bus.pm_ready_i;
    end

    assign bus.pm_rd_o    = grant_a || grant_f;
    assign bus.pm_addr_o  = grant_a ? bus.a_addr_i : (grant_f ? bus.f_addr_i : '0);
    assign bus.f_ready_o  = grant_f && bus.pm_ready_i;
    assign bus.a_ready_o  = grant_a && bus.pm_ready_i;
    // Fetch data popped during a redirect belongs to the old stream.
    assign bus.f_rvalid_o = pop && !head_tag && !head_disc && !bus.f_flush_i;
    assign bus.a_rvalid_o = pop && head_tag;
    assign bus.f_rdata_o  = bus.f_rvalid_o ? bus.pm_rdata_i : '0;
    assign bus.a_rdata_o  = bus.a_rvalid_o ? bus.pm_rdata_i : '0;
    assign outstanding_o  = count_q;
    assign proto_err_o    = proto_err_q;

    always_comb begin
        count_d  = count_q + {3'd0, push} - {3'd0, pop};
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        tag_d    = tag_q;
        // Flush marks every fetch entry already in flight; the request pushed
        // in the same cycle is the redirected one, so it is written clean.
        disc_d   = bus.f_flush_i ? (disc_q | ~tag_q) : disc_q;
        if (push) begin
            tag_d[wr_ptr_q]  = grant_a;
            disc_d[wr_ptr_q] = 1'b0;
        end

        wait_cnt_d = wait_cnt_q;
        if (!bus.a_rd_i || (grant_a && bus.pm_ready_i)) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        proto_err_d = proto_err_q || (bus.pm_rvalid_i && (count_q == 4'd0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q     <= 4'd0;
            wr_ptr_q    <= 3'd0;
            rd_ptr_q    <= 3'd0;
            tag_q       <= 8'd0;
            disc_q      <= 8'd0;
            wait_cnt_q  <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_q       <= tag_d;
            disc_q      <= disc_d;
            wait_cnt_q  <= wait_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule
